if_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the pipelined RISC core.
- Holds the PC, a byte-addressed instruction store with a program-load write port, and the IF/ID output register.
- Fetches INSTR_BYTES-wide big-endian instructions and advances the PC by INSTR_BYTES per cycle.
- Supports stall, branch redirect, flush, and a HALT-opcode stop state; feeds the decode stage.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/imem_bytes.sv | 31 +++
 rtl/if_fetch_unit.sv | 105 ++++++++++
 tb/tb_if_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: fetch FSM states, HALT opcode, default fetch geometry,
// and the IF/ID pipeline record consumed by decode.
package cpu_pkg;

    localparam int         ADDR_W_DEF      = 8;
    localparam int         INSTR_BYTES_DEF = 2;
    localparam logic [3:0] OPC_HALT        = 4'b1100;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic                           valid;
        logic [ADDR_W_DEF-1:0]          pc;
        logic [8*INSTR_BYTES_DEF-1:0]   instr;
    } if_id_t;

endpackage

// File: rtl/imem_bytes.sv
// Byte-wide instruction store: one synchronous write port and LANES
// combinational read lanes; lane i reads raddr+i with natural address wrap.
module imem_bytes
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = INSTR_BYTES_DEF
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [7:0]          wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [8*LANES-1:0]  rdata
);

    logic [7:0] mem_q [2**ADDR_W];

    // No reset: program contents survive a core reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ADDR_W-1:0] addr;
        assign addr = raddr + ADDR_W'(i);
        // First byte lands in the most significant lane (big-endian).
        assign rdata[8*(LANES-1-i) +: 8] = mem_q[addr];
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, RUN/HALT FSM, byte store and IF/ID register.
// Redirect beats stall beats plain advance; HALT parks fetch until a redirect.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int         ADDR_W      = ADDR_W_DEF,
    parameter int         INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int         RESET_PC    = 0,
    parameter logic [3:0] HALT_OP     = OPC_HALT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    input  logic                      flush,
    input  logic                      prog_we,
    input  logic [ADDR_W-1:0]         prog_addr,
    input  logic [7:0]                prog_data,
    output logic                      out_valid,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [8*INSTR_BYTES-1:0]  out_instr,
    output logic                      halted
);

    localparam int               IW         = 8 * INSTR_BYTES;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   opc_q, opc_d;
    logic [IW-1:0]       instr_q, instr_d;
    logic [IW-1:0]       fetch_word;
    logic [ADDR_W-1:0]   redir_aligned;

    imem_bytes #(
        .ADDR_W (ADDR_W),
        .LANES  (INSTR_BYTES)
    ) u_imem (
        .clk    (clk),
        .we     (prog_we),
        .waddr  (prog_addr),
        .wdata  (prog_data),
        .raddr  (pc_q),
        .rdata  (fetch_word)
    );

    assign redir_aligned = redirect_pc & ALIGN_MASK;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        instr_d = instr_q;
        unique case (state_q)
            FS_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redir_aligned;
                    valid_d = 1'b0;
                end else if (stall) begin
                    if (flush) valid_d = 1'b0;
                end else begin
                    opc_d   = pc_q;
                    instr_d = fetch_word;
                    valid_d = ~flush;
                    pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
                    // A flushed halt never issued, so it must not stop fetch.
                    if (!flush && fetch_word[IW-1 -: 4] == HALT_OP) state_d = FS_HALT;
                end
            end
            FS_HALT: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redir_aligned;
                    state_d = FS_RUN;
                end
            end
            default: state_d = FS_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_RUN;
            pc_q    <= ADDR_W'(RESET_PC);
            valid_q <= 1'b0;
            opc_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            instr_q <= instr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = opc_q;
    assign out_instr = instr_q;
    assign halted    = (state_q == FS_HALT);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: each driven cycle pushes the reference
// model's expected post-edge outputs; a monitor pops and compares every cycle.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, flush, prog_we;
    logic [7:0]  redirect_pc, prog_addr, prog_data;
    logic        out_valid, halted;
    logic [7:0]  out_pc;
    logic [15:0] out_instr;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .out_valid(out_valid),
        .out_pc(out_pc), .out_instr(out_instr), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [7:0]  pc;
        logic [15:0] instr;
        logic        halted;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: plain integers and a byte array.
    logic [7:0] mmem [256];
    int   m_pc;
    bit   m_halt;
    bit   e_valid;
    int   e_pc;
    int   e_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs and advance the model across the next edge.
    task automatic cyc(input bit rst, input bit stl, input bit rv, input int rpc,
                       input bit fl, input bit we, input int wa, input int wd);
        int f;
        exp_t e;
        @(negedge clk);
        reset = rst; stall = stl; redirect_valid = rv; redirect_pc = 8'(rpc);
        flush = fl; prog_we = we; prog_addr = 8'(wa); prog_data = 8'(wd);
        f = {mmem[m_pc], mmem[(m_pc + 1) % 256]};
        if (rst) begin
            m_pc = 0; m_halt = 0; e_valid = 0; e_pc = 0; e_instr = 0;
        end else if (m_halt) begin
            e_valid = 0;
            if (rv) begin m_pc = (rpc / 2) * 2; m_halt = 0; end
        end else if (rv) begin
            m_pc = (rpc / 2) * 2; e_valid = 0;
        end else if (stl) begin
            if (fl) e_valid = 0;
        end else begin
            e_pc = m_pc; e_instr = f; e_valid = !fl;
            if (!fl && (f / 4096) == 12) m_halt = 1;
            m_pc = (m_pc + 2) % 256;
        end
        if (we) mmem[wa] = 8'(wd);
        e.valid = e_valid; e.pc = 8'(e_pc); e.instr = 16'(e_instr); e.halted = m_halt;
        sbq.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Independent spot checks of literal values, sampled after the edge.
    task automatic spot(input string name, input logic v, input int pc, input int instr);
        @(posedge clk); #2;
        chk({name, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            chk({name, ".pc"}, 32'(out_pc), 32'(pc));
            chk({name, ".instr"}, 32'(out_instr), 32'(instr));
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb.valid",  32'(out_valid), 32'(e.valid));
            chk("sb.halted", 32'(halted),    32'(e.halted));
            chk("sb.pc",     32'(out_pc),    32'(e.pc));
            chk("sb.instr",  32'(out_instr), 32'(e.instr));
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] prog [6];
        int wait_n;
        prog[0] = 8'h00; prog[1] = 8'h00; prog[2] = 8'h70;
        prog[3] = 8'h00; prog[4] = 8'hE0; prog[5] = 8'hFF;
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        m_pc = 0; m_halt = 0; e_valid = 0; e_pc = 0; e_instr = 0;
        reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        flush = 0; prog_we = 0; prog_addr = 0; prog_data = 0;

        // Program load during reset; keep halt opcodes out of the base image.
        for (int a = 0; a < 256; a++) begin
            b = 8'($urandom);
            if (a % 2 == 0 && b[7:4] == 4'hC) b = b ^ 8'h10;
            if (a < 6) b = prog[a];
            cyc(1, 0, 0, 0, 0, 1, a, b);
        end
        @(posedge clk); #2;
        chk("reset.valid", 32'(out_valid), 0);
        chk("reset.pc", 32'(out_pc), 0);
        chk("reset.halted", 32'(halted), 0);

        // 1+2: sequential fetch, then stall with PC at 0x04
        cyc(0, 0, 0, 0, 0, 0, 0, 0); spot("t1a", 1, 8'h00, 16'h0000);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); spot("t1b", 1, 8'h02, 16'h7000);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); spot("t2s0", 1, 8'h02, 16'h7000);
        cyc(0, 1, 0, 0, 0, 0, 0, 0); spot("t2s1", 1, 8'h02, 16'h7000);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); spot("t1c", 1, 8'h04, 16'hE0FF);

        // 3: redirect beats stall, target is aligned down
        cyc(0, 1, 1, 8'h15, 1, 0, 0, 0); spot("t3bub", 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2; chk("t3.pc", 32'(out_pc), 32'h14);

        // 4: HALT instruction, stall/flush ignored, redirect resumes
        cyc(0, 1, 0, 0, 0, 1, 8'h40, 8'hC0);
        cyc(0, 1, 0, 0, 0, 1, 8'h41, 8'h00);
        cyc(0, 0, 1, 8'h40, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); spot("t4halt", 1, 8'h40, 16'hC000);
        for (int i = 0; i < 4; i++) begin
            cyc(0, i[0], 0, 0, i[1], 0, 0, 0);
            @(posedge clk); #2;
            chk("t4.halted", 32'(halted), 1);
            chk("t4.valid", 32'(out_valid), 0);
        end
        cyc(0, 0, 1, 8'h00, 0, 0, 0, 0);
        @(posedge clk); #2; chk("t4.resume", 32'(halted), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); spot("t4pc0", 1, 8'h00, 16'h0000);

        // 5: byte-address and PC wrap
        cyc(0, 1, 0, 0, 0, 1, 8'hFF, 8'hAB);
        cyc(0, 1, 0, 0, 0, 1, 8'h00, 8'hCD);
        cyc(0, 0, 1, 8'hFE, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0); spot("t5fe", 1, 8'hFE, {mmem[8'hFE], 8'hAB});
        cyc(0, 0, 0, 0, 0, 0, 0, 0); spot("t5wrap", 1, 8'h00, {8'hCD, mmem[1]});

        // 6: read-before-write, refetch, then reset mid-stream
        cyc(0, 0, 1, 8'h30, 0, 0, 0, 0);
        b = mmem[8'h30];
        cyc(0, 0, 0, 0, 0, 1, 8'h30, 8'h11);
        @(posedge clk); #2; chk("t6.old", 32'(out_instr[15:8]), 32'(b));
        cyc(0, 0, 1, 8'h30, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2; chk("t6.new", 32'(out_instr[15:8]), 32'h11);
        run(3);
        cyc(1, 1, 1, 8'h80, 0, 0, 0, 0); spot("t6rst", 0, 0, 0);
        chk("t6rst.pc", 32'(out_pc), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0), int'($urandom_range(0, 255)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        wait_n = 0;
        while (sbq.size() > 0 && wait_n < 10) begin
            @(posedge clk); #2;
            wait_n++;
        end
        chk("drain", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
